// File: rtl/joysega_pkg.sv
// Shared types and constants for the multi-port Mega Drive pad scanner.
package joysega_pkg;

   typedef enum logic [1:0] {
      PAD_NONE = 2'd0,
      PAD_3BTN = 2'd1,
      PAD_6BTN = 2'd2
   } pad_type_e;

   typedef enum logic {
      SEQ_IDLE = 1'b0,
      SEQ_SCAN = 1'b1
   } seq_state_e;

   localparam int BTN_W = 12;

   localparam int BTN_UP    = 0;
   localparam int BTN_DOWN  = 1;
   localparam int BTN_LEFT  = 2;
   localparam int BTN_RIGHT = 3;
   localparam int BTN_B1    = 4;
   localparam int BTN_B2    = 5;
   localparam int BTN_B3    = 6;
   localparam int BTN_START = 7;
   localparam int BTN_X     = 8;
   localparam int BTN_Y     = 9;
   localparam int BTN_Z     = 10;
   localparam int BTN_MODE  = 11;

   // Raw pad line packing inside a port: {b2, b1, right, left, down, up}
   localparam int LN_UP    = 0;
   localparam int LN_DOWN  = 1;
   localparam int LN_LEFT  = 2;
   localparam int LN_RIGHT = 3;
   localparam int LN_B1    = 4;
   localparam int LN_B2    = 5;
   localparam int LN_W     = 6;

endpackage

// File: rtl/joysega_port.sv
// One gamepad port: input synchronisers, per-step shadow capture, pad
// classification and atomic commit to the published button vector.
// Optional feature macro: JOYSEGA_TURBO_EN (turbo merge of x/y/z into b3/b1/b2).
module joysega_port
   import joysega_pkg::*;
(
   input  logic              clk28,
   input  logic              rst,
   input  logic [LN_W-1:0]   n_lines,
   input  logic [2:0]        step_idx,
   input  logic              sample_en,
   input  logic              commit_en,
   input  logic              turbo_strobe,
   output logic [BTN_W-1:0]  btn,
   output logic [1:0]        pad_type,
   output logic [2:0]        btn_turbo
);

   logic [LN_W-1:0] sync_q1;
   logic [LN_W-1:0] sync_q2;
   logic            conn_q;
   logic            six_q;
   logic            b3_q;
   logic            start_q;
   logic            b1_q;
   logic            b2_q;
   logic [3:0]      dir_q;
   logic [3:0]      xyzm_q;   // {mode, z, y, x}

   // Two-flop synchroniser on the raw active-low pad lines (idle high)
   always_ff @(posedge clk28 or posedge rst) begin
      if (rst) begin
         sync_q1 <= '1;
         sync_q2 <= '1;
      end else begin
         sync_q1 <= n_lines;
         sync_q2 <= sync_q1;
      end
   end

   // Shadow capture: each select step contributes its own fields
   always_ff @(posedge clk28 or posedge rst) begin
      if (rst) begin
         conn_q  <= 1'b0;
         six_q   <= 1'b0;
         b3_q    <= 1'b0;
         start_q <= 1'b0;
         b1_q    <= 1'b0;
         b2_q    <= 1'b0;
         dir_q   <= '0;
         xyzm_q  <= '0;
      end else if (sample_en) begin
         case (step_idx)
            3'd2: begin
               conn_q  <= ~sync_q2[LN_LEFT] & ~sync_q2[LN_RIGHT];
               b3_q    <= ~sync_q2[LN_B1];
               start_q <= ~sync_q2[LN_B2];
            end
            3'd3: begin
               dir_q <= ~sync_q2[LN_RIGHT:LN_UP];
               b1_q  <= ~sync_q2[LN_B1];
               b2_q  <= ~sync_q2[LN_B2];
            end
            3'd4: begin
               six_q <= conn_q & ~sync_q2[LN_UP] & ~sync_q2[LN_DOWN];
            end
            3'd5: begin
               // on the third high phase a 6-button pad muxes z/y/x/mode onto the directions
               xyzm_q <= six_q ? {~sync_q2[LN_RIGHT], ~sync_q2[LN_UP],
                                  ~sync_q2[LN_DOWN],  ~sync_q2[LN_LEFT]} : 4'b0000;
            end
            default: ;
         endcase
      end
   end

   // Publish all shadow fields in a single cycle; an unconnected pad reads as all-released
   always_ff @(posedge clk28 or posedge rst) begin
      if (rst) begin
         btn      <= '0;
         pad_type <= PAD_NONE;
      end else if (commit_en) begin
         btn      <= conn_q ? {xyzm_q, start_q, b3_q, b2_q, b1_q, dir_q} : '0;
         pad_type <= !conn_q ? PAD_NONE : (six_q ? PAD_6BTN : PAD_3BTN);
      end
   end

`ifdef JOYSEGA_TURBO_EN
   assign btn_turbo = {btn[BTN_B3] | (btn[BTN_X] & turbo_strobe),
                       btn[BTN_B2] | (btn[BTN_Z] & turbo_strobe),
                       btn[BTN_B1] | (btn[BTN_Y] & turbo_strobe)};
`else
   logic unused_turbo;
   assign unused_turbo = turbo_strobe;
   assign btn_turbo    = {btn[BTN_B3], btn[BTN_B2], btn[BTN_B1]};
`endif

endmodule

// File: rtl/joysega_multi.sv
// Multi-port Mega Drive pad scanner: one shared 8-step select sequencer
// driving PORTS joysega_port instances in parallel.
// Optional feature macro: JOYSEGA_TURBO_EN (handled inside joysega_port).
//
// state    | meaning
// SEQ_IDLE | joy_sel high, waiting for poll_req
// SEQ_SCAN | stepping through select steps 0..7, busy high
module joysega_multi
   import joysega_pkg::*;
#(
   parameter int PORTS       = 2,
   parameter int STEP_CYCLES = 128,
   parameter int SAMPLE_AT   = 120
) (
   input  logic                    clk28,
   input  logic                    rst,
   input  logic                    poll_req,
   input  logic                    turbo_strobe,
   input  logic [PORTS-1:0]        n_joy_up,
   input  logic [PORTS-1:0]        n_joy_down,
   input  logic [PORTS-1:0]        n_joy_left,
   input  logic [PORTS-1:0]        n_joy_right,
   input  logic [PORTS-1:0]        n_joy_b1,
   input  logic [PORTS-1:0]        n_joy_b2,
   output logic [PORTS-1:0]        joy_sel,
   output logic                    busy,
   output logic                    done,
   output logic [2*PORTS-1:0]      pad_type,
   output logic [BTN_W*PORTS-1:0]  btn,
   output logic [3*PORTS-1:0]      btn_turbo
);

   localparam int CNT_W = $clog2(STEP_CYCLES);
   // step timer counts down; cycle index k inside a step sits at count STEP_CYCLES-1-k
   localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(STEP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(STEP_CYCLES - 1 - SAMPLE_AT);

   seq_state_e       state_q;
   seq_state_e       state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       step_q;
   logic             step_end;
   logic             last_step;
   logic             sample_en;
   logic             commit_en;
   logic             sel_lvl;
   logic             done_q;

   assign step_end  = (cnt_q == '0);
   assign last_step = step_end && (step_q == 3'd7);

   // State register
   always_ff @(posedge clk28 or posedge rst) begin
      if (rst) state_q <= SEQ_IDLE;
      else     state_q <= state_d;
   end

   // Next-state: start on request, return to idle when step 7 expires
   always_comb begin
      state_d = state_q;
      case (state_q)
         SEQ_IDLE: if (poll_req)  state_d = SEQ_SCAN;
         SEQ_SCAN: if (last_step) state_d = SEQ_IDLE;
         default:                 state_d = SEQ_IDLE;
      endcase
   end

   // Outputs and per-port enables decoded from state and timer
   always_comb begin
      busy      = (state_q == SEQ_SCAN);
      sel_lvl   = (state_q == SEQ_SCAN) ? step_q[0] : 1'b1;
      sample_en = (state_q == SEQ_SCAN) && (cnt_q == CNT_SAMPLE);
      commit_en = (state_q == SEQ_SCAN) && last_step;
   end

   // Step timer and step index
   always_ff @(posedge clk28 or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         step_q <= '0;
      end else if (state_q == SEQ_IDLE) begin
         cnt_q  <= poll_req ? CNT_LOAD : '0;
         step_q <= '0;
      end else if (step_end) begin
         cnt_q  <= last_step ? '0 : CNT_LOAD;
         step_q <= step_q + 3'd1;
      end else begin
         cnt_q  <= cnt_q - CNT_W'(1);
      end
   end

   // Completion strobe lines up with the commit of the port registers
   always_ff @(posedge clk28 or posedge rst) begin
      if (rst) done_q <= 1'b0;
      else     done_q <= commit_en;
   end

   assign done    = done_q;
   assign joy_sel = {PORTS{sel_lvl}};

   for (genvar p = 0; p < PORTS; p++) begin : g_port
      joysega_port u_port (
         .clk28        (clk28),
         .rst          (rst),
         .n_lines      ({n_joy_b2[p], n_joy_b1[p], n_joy_right[p],
                         n_joy_left[p], n_joy_down[p], n_joy_up[p]}),
         .step_idx     (step_q),
         .sample_en    (sample_en),
         .commit_en    (commit_en),
         .turbo_strobe (turbo_strobe),
         .btn          (btn[p*BTN_W +: BTN_W]),
         .pad_type     (pad_type[2*p +: 2]),
         .btn_turbo    (btn_turbo[3*p +: 3])
      );
   end

endmodule
